// File: rtl/pf_io_delay_ctrl_pkg.sv
// pf_io_delay_ctrl_pkg: shared types and defaults for the PF_IO
// dynamic delay-line sequencer.
package pf_io_delay_ctrl_pkg;

   typedef enum logic [2:0] {
      INIT_LOAD,
      INIT_SETTLE,
      IDLE,
      LOAD,
      LSETTLE,
      STEP,
      SETTLE,
      FINISH
   } dly_state_e;

   localparam logic DLY_INC = 1'b1;
   localparam logic DLY_DEC = 1'b0;

   localparam int DEF_LOAD_CYCLES   = 2;
   localparam int DEF_SETTLE_CYCLES = 3;

endpackage

// File: rtl/pf_io_delay_ctrl.sv
// pf_io_delay_ctrl: reloads and steps a PF_IO dynamic delay line
// one tap at a time, tracking the current tap.
module pf_io_delay_ctrl
   import pf_io_delay_ctrl_pkg::*;
#(
   parameter int TAP_W         = 8,
   parameter int MAX_TAP       = 127,
   parameter int INIT_TAP      = 1,
   parameter int LOAD_CYCLES   = DEF_LOAD_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [TAP_W-1:0] CMD_TARGET,
   input  logic             CMD_RELOAD,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   input  logic             DELAY_LINE_OUT_OF_RANGE,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             DONE,
   output logic             ERR
);

   localparam int CNT_MAX =
      (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LOAD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   localparam logic [TAP_W-1:0] MAX_T   = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] INIT_T  = TAP_W'(INIT_TAP);
   localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);

   dly_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [TAP_W-1:0] tgt;
   logic             moved;

   logic go_up;
   logic at_top;
   logic at_bot;
   logic blocked;
   logic accept;

   assign go_up   = tgt > CUR_TAP;
   assign at_top  = CUR_TAP >= MAX_T;
   assign at_bot  = CUR_TAP == '0;
   assign blocked = go_up ? at_top : at_bot;
   assign accept  = CMD_VALID && CMD_READY;

   // One counter times both the LOAD width and every settle gap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state                <= INIT_LOAD;
         cnt                  <= CNT_LOAD;
         tgt                  <= '0;
         moved                <= 1'b0;
         CMD_READY            <= 1'b0;
         DELAY_LINE_LOAD      <= 1'b0;
         DELAY_LINE_MOVE      <= 1'b0;
         DELAY_LINE_DIRECTION <= DLY_DEC;
         CUR_TAP              <= INIT_T;
         DONE                 <= 1'b0;
         ERR                  <= 1'b0;
      end else begin
         unique case (state)
            INIT_LOAD: begin
               DELAY_LINE_LOAD <= 1'b1;
               if (cnt == CNT_ONE) begin
                  state <= INIT_SETTLE;
                  cnt   <= CNT_SETTLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            INIT_SETTLE: begin
               DELAY_LINE_LOAD <= 1'b0;
               if (cnt == CNT_ONE) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            IDLE: begin
               CMD_READY <= 1'b1;
               if (accept) begin
                  CMD_READY <= 1'b0;
                  ERR       <= 1'b0;
                  tgt       <= CMD_TARGET;
                  moved     <= 1'b0;
                  // An illegal target skips the reload entirely.
                  if (CMD_RELOAD && CMD_TARGET <= MAX_T) begin
                     state <= LOAD;
                     cnt   <= CNT_LOAD;
                  end else begin
                     state <= STEP;
                  end
               end
            end

            LOAD: begin
               DELAY_LINE_LOAD <= 1'b1;
               CUR_TAP         <= INIT_T;
               if (cnt == CNT_ONE) begin
                  state <= LSETTLE;
                  cnt   <= CNT_SETTLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            LSETTLE: begin
               DELAY_LINE_LOAD <= 1'b0;
               if (cnt == CNT_ONE) begin
                  state <= STEP;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            STEP: begin
               if (moved && DELAY_LINE_OUT_OF_RANGE) begin
                  // Undo the last move; the line refused it.
                  CUR_TAP <= (DELAY_LINE_DIRECTION == DLY_INC)
                           ? CUR_TAP - TAP_ONE
                           : CUR_TAP + TAP_ONE;
                  ERR   <= 1'b1;
                  DONE  <= 1'b1;
                  state <= FINISH;
               end else if (tgt > MAX_T) begin
                  ERR   <= 1'b1;
                  DONE  <= 1'b1;
                  state <= FINISH;
               end else if (tgt == CUR_TAP) begin
                  DONE  <= 1'b1;
                  state <= FINISH;
               end else if (blocked) begin
                  ERR   <= 1'b1;
                  DONE  <= 1'b1;
                  state <= FINISH;
               end else begin
                  DELAY_LINE_MOVE      <= 1'b1;
                  DELAY_LINE_DIRECTION <= go_up ? DLY_INC : DLY_DEC;
                  moved                <= 1'b1;
                  cnt                  <= CNT_SETTLE;
                  state                <= SETTLE;
               end
            end

            SETTLE: begin
               if (DELAY_LINE_MOVE) begin
                  DELAY_LINE_MOVE <= 1'b0;
                  CUR_TAP <= (DELAY_LINE_DIRECTION == DLY_INC)
                           ? CUR_TAP + TAP_ONE
                           : CUR_TAP - TAP_ONE;
               end
               if (cnt == CNT_ONE) begin
                  state <= STEP;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            FINISH: begin
               DONE      <= 1'b0;
               CMD_READY <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state <= INIT_LOAD;
               cnt   <= CNT_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pf_io_delay_ctrl.sv
// tb_pf_io_delay_ctrl: directed vector bench for the delay-line
// sequencer, plus reset auto-load and reset-abort sequences.
module tb_pf_io_delay_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CMD_VALID = 1'b0;
   logic       CMD_READY;
   logic [7:0] CMD_TARGET = '0;
   logic       CMD_RELOAD = 1'b0;
   logic       DELAY_LINE_LOAD;
   logic       DELAY_LINE_MOVE;
   logic       DELAY_LINE_DIRECTION;
   logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic [7:0] CUR_TAP;
   logic       DONE;
   logic       ERR;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   pf_io_delay_ctrl dut (
      .CLK                     (CLK),
      .RST                     (RST),
      .CMD_VALID               (CMD_VALID),
      .CMD_READY               (CMD_READY),
      .CMD_TARGET              (CMD_TARGET),
      .CMD_RELOAD              (CMD_RELOAD),
      .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
      .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
      .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
      .CUR_TAP                 (CUR_TAP),
      .DONE                    (DONE),
      .ERR                     (ERR)
   );

   typedef struct {
      logic [7:0] tgt;
      logic       rl;
      int         oor_k;
      int         lat;
      int         moves;
      logic       dir;
      int         loads;
      logic       err;
      int         tap;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  n;
      int  moves;
      int  loads;
      int  bad_t;
      int  bad_d;
      int  lat;
      int  first;
      int  w;
      bit  seen;
      int  err_v;
      int  tap_v;
      string pfx;
      pfx   = $sformatf("v%0d", idx);
      moves = 0;
      loads = 0;
      bad_t = 0;
      bad_d = 0;
      lat   = -1;
      err_v = -1;
      tap_v = -1;
      first = v.rl ? 6 : 1;
      seen  = 0;
      for (w = 0; w < 50 && !seen; w++) begin
         if (CMD_READY) seen = 1;
         else tick();
      end
      if (!seen) chk({pfx, "_ready_wait"}, 0, 1);
      CMD_VALID  = 1'b1;
      CMD_TARGET = v.tgt;
      CMD_RELOAD = v.rl;
      tick();
      CMD_VALID  = 1'b0;
      CMD_TARGET = ~v.tgt;
      CMD_RELOAD = ~v.rl;
      for (n = 1; n <= 700 && lat < 0; n++) begin
         tick();
         if (DELAY_LINE_MOVE) begin
            if (n != first + moves * 4) bad_t++;
            if (DELAY_LINE_DIRECTION != v.dir) bad_d++;
            moves++;
            if (v.oor_k != 0 && moves == v.oor_k)
               DELAY_LINE_OUT_OF_RANGE = 1'b1;
         end
         if (DELAY_LINE_LOAD) begin
            if (v.loads == 0 || n > 2) bad_t++;
            loads++;
         end
         if (DONE) begin
            lat   = n;
            err_v = int'(ERR);
            tap_v = int'(CUR_TAP);
         end
      end
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      chk({pfx, "_done_lat"}, lat, v.lat);
      chk({pfx, "_moves"}, moves, v.moves);
      chk({pfx, "_loads"}, loads, v.loads);
      chk({pfx, "_err"}, err_v, int'(v.err));
      chk({pfx, "_tap"}, tap_v, v.tap);
      chk({pfx, "_timing"}, bad_t, 0);
      chk({pfx, "_dir"}, bad_d, 0);
      tick();
      chk({pfx, "_ready_after"}, int'({CMD_READY, DONE}), 2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [6:0] load_seq;
      bit [6:0] rdy_seq;
      bit [6:0] done_seq;
      bit       seen;

      vecs[0] = '{8'd5,   1'b0, 0, 17,  4,   1'b1, 0, 1'b0, 5};
      vecs[1] = '{8'd0,   1'b1, 0, 10,  1,   1'b0, 2, 1'b0, 0};
      vecs[2] = '{8'd1,   1'b0, 0, 5,   1,   1'b1, 0, 1'b0, 1};
      vecs[3] = '{8'd10,  1'b0, 2, 9,   2,   1'b1, 0, 1'b1, 2};
      vecs[4] = '{8'd200, 1'b1, 0, 1,   0,   1'b0, 0, 1'b1, 2};
      vecs[5] = '{8'd2,   1'b0, 0, 1,   0,   1'b0, 0, 1'b0, 2};
      vecs[6] = '{8'd127, 1'b1, 0, 510, 126, 1'b1, 2, 1'b0, 127};
      vecs[7] = '{8'd128, 1'b0, 0, 1,   0,   1'b0, 0, 1'b1, 127};
      vecs[8] = '{8'd127, 1'b0, 0, 1,   0,   1'b0, 0, 1'b0, 127};
      vecs[9] = '{8'd0,   1'b0, 0, 509, 127, 1'b0, 0, 1'b0, 0};

      RST = 1'b1;
      tick();
      tick();
      tick();
      chk("rst_outs",
          int'({CMD_READY, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                DELAY_LINE_DIRECTION, DONE, ERR}), 0);
      chk("rst_tap", int'(CUR_TAP), 1);

      RST = 1'b0;
      for (int n = 0; n < 7; n++) begin
         tick();
         load_seq[n] = DELAY_LINE_LOAD;
         rdy_seq[n]  = CMD_READY;
         done_seq[n] = DONE;
      end
      chk("init_load_seq", int'(load_seq), 7'b0000011);
      chk("init_ready_seq", int'(rdy_seq), 7'b1100000);
      chk("init_done_seq", int'(done_seq), 0);
      chk("init_tap", int'(CUR_TAP), 1);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      CMD_VALID  = 1'b1;
      CMD_TARGET = 8'd10;
      CMD_RELOAD = 1'b0;
      tick();
      CMD_VALID = 1'b0;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         if (DELAY_LINE_MOVE) seen = 1;
         else tick();
      end
      chk("abort_move_seen", int'(seen), 1);
      RST = 1'b1;
      tick();
      chk("abort_move_low", int'(DELAY_LINE_MOVE), 0);
      chk("abort_tap", int'(CUR_TAP), 1);
      chk("abort_err", int'(ERR), 0);
      RST = 1'b0;
      tick();
      chk("abort_reload", int'(DELAY_LINE_LOAD), 1);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (CMD_READY) seen = 1;
         else tick();
      end
      chk("abort_ready", int'(seen), 1);
      chk("abort_tap_idle", int'(CUR_TAP), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pf_io_delay_ctrl.md
# pf_io_delay_ctrl

Sequencer that drives the dynamic delay-line control pins of a `PF_IO` instance built with `DYN_DELAY_LINE_EN=1`: `DELAY_LINE_LOAD`, `DELAY_LINE_MOVE` and `DELAY_LINE_DIRECTION`, with `DELAY_LINE_OUT_OF_RANGE` as feedback. It accepts a target tap count over a valid/ready command port, then reloads and/or steps the delay line one tap at a time. Between taps it enforces settle spacing and tracks the current tap. It sits in fabric next to each trained I/O, between the training/calibration logic and the I/O wrapper.

## Interface
Parameters:
- `TAP_W`, 8, tap counter width.
- `MAX_TAP`, 127, highest legal tap.
- `INIT_TAP`, 1, tap value restored by a LOAD; must equal the I/O's static delay value.
- `LOAD_CYCLES`, 2, LOAD pulse width in cycles (≥1).
- `SETTLE_CYCLES`, 3, idle cycles after each LOAD/MOVE before the next action or range check (≥1).

Ports:
- `CLK` in 1: the only clock. One clock; reset is synchronous and active-high.
- `RST` in 1: synchronous, active-high reset.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: high only in IDLE.
- `CMD_TARGET` in TAP_W: requested tap.
- `CMD_RELOAD` in 1: perform LOAD before stepping.
- `DELAY_LINE_LOAD` out 1: to `PF_IO`.
- `DELAY_LINE_MOVE` out 1: to `PF_IO`.
- `DELAY_LINE_DIRECTION` out 1: to `PF_IO`; 1 = increment, 0 = decrement.
- `DELAY_LINE_OUT_OF_RANGE` in 1: from `PF_IO`, same clock domain.
- `CUR_TAP` out TAP_W: tracked tap.
- `DONE` out 1: one-cycle completion pulse.
- `ERR` out 1: sticky error flag, cleared when the next command is accepted.

## Operation
- States: INIT_LOAD, INIT_SETTLE, IDLE, LOAD, LSETTLE, STEP, SETTLE, FINISH.
- Reset values:
  - `CMD_READY`, `DELAY_LINE_LOAD`, `DELAY_LINE_MOVE`, `DELAY_LINE_DIRECTION`, `DONE` and `ERR` are all 0.
  - `CUR_TAP` = INIT_TAP.
  - State = INIT_LOAD.
- Auto-load after reset: INIT_LOAD holds LOAD for LOAD_CYCLES, then INIT_SETTLE waits SETTLE_CYCLES, then the block enters IDLE. No DONE pulse is generated.
- Command acceptance is `CMD_VALID && CMD_READY`. On accept:
  - ERR is cleared.
  - Target is latched; target and RELOAD inputs are ignored afterwards.
- Target > MAX_TAP: go straight to FINISH with ERR=1; no LOAD and no MOVE.
- RELOAD=1: LOAD high for LOAD_CYCLES, `CUR_TAP` := INIT_TAP, then LSETTLE waits SETTLE_CYCLES, then STEP.
- STEP:
  - If `CUR_TAP` == target, go to FINISH.
  - Otherwise set DIRECTION = (target > `CUR_TAP`) and assert MOVE for exactly one cycle; `CUR_TAP` ±1 at the end of that cycle. Then SETTLE.
- DIRECTION is registered and changes only in the cycle MOVE is asserted. Because that cycle is preceded by settle cycles, DIRECTION is stable before and during MOVE.
- SETTLE waits SETTLE_CYCLES, then samples OUT_OF_RANGE:
  - If high: `CUR_TAP` reverts to its pre-move value, ERR=1, go to FINISH.
  - Otherwise return to STEP.
- FINISH: DONE=1 for one cycle, then IDLE.
- Counter arithmetic is width TAP_W with no wrap: `CUR_TAP` never leaves 0..MAX_TAP. A decrement at 0 or an increment at MAX_TAP is not issued and is treated as OUT_OF_RANGE.
- RST at any time aborts the operation:
  - LOAD/MOVE drop at that edge.
  - `CUR_TAP` = INIT_TAP.
  - The auto-load sequence restarts.

## Timing
- Accept at cycle A (edge where VALID&&READY).
- With no reload and N moves:
  - MOVE pulses at A+1 + k·(SETTLE_CYCLES+1), for k = 0..N-1.
  - DONE at A+1 + N·(SETTLE_CYCLES+1).
  - N=0 gives DONE at A+1.
- With reload, add LOAD_CYCLES+SETTLE_CYCLES to every figure above; LOAD is high over A+1..A+LOAD_CYCLES.
- Out-of-range on move k: DONE at A+1 + (k+1)·(SETTLE_CYCLES+1), with ERR=1 in the same cycle.
- `CMD_READY` rises the cycle after DONE. A back-to-back command may be accepted in that cycle.
- After RST is released at cycle R:
  - LOAD is high over R..R+LOAD_CYCLES-1.
  - READY goes high at R+LOAD_CYCLES+SETTLE_CYCLES.

## Structure
- Package `pf_io_delay_ctrl_pkg` holds:
  - the state enum;
  - direction constants `DLY_INC`=1 and `DLY_DEC`=0;
  - the default LOAD_CYCLES/SETTLE_CYCLES values.
- Single module with no sub-module. One shared down-counter serves both the LOAD width and the settle spacing.

## Test plan
- Reset auto-load: defaults; RST released at R → LOAD high at R, R+1; READY high at R+5; `CUR_TAP`=1; no DONE.
- Step up: target 5, no reload → 4 MOVE pulses with DIRECTION=1, spaced 4 cycles apart; DONE at A+17; `CUR_TAP`=5; ERR=0.
- Reload + step down: `CUR_TAP`=5, target 0, RELOAD=1 → LOAD over A+1..A+2, `CUR_TAP`=1; one MOVE with DIRECTION=0 at A+6; DONE at A+10; `CUR_TAP`=0.
- Range error: force OUT_OF_RANGE high after the 2nd move of target 10 from 1 → DONE at A+9, ERR=1, `CUR_TAP`=2, no 3rd MOVE.
- Illegal/trivial targets:
  - Target 200 → DONE at A+1, ERR=1, no LOAD/MOVE.
  - Target == `CUR_TAP` → DONE at A+1, ERR=0.
- Reset mid-move: RST asserted in the MOVE cycle → MOVE low next cycle, `CUR_TAP`=1, auto-load LOAD follows, ERR=0.
